koopa_anim_sequencer: RTL and testbench

//  Sequences all Koopa sprite animations: picks the active animation from movement requests and
//  one-shot triggers, steps frames with per-animation hold times on anim_tick, and emits the

---
 rtl/koopa_anim_sequencer_if.sv | 37 +++
 rtl/koopa_anim_sequencer.sv | 131 +++++++++++++
 tb/tb_koopa_anim_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/koopa_anim_sequencer_if.sv
// Koopa sprite animation sequencer bus: requests in, sheet offsets and status out.
// ANIM_FREEZE_EN adds the freeze input.
interface koopa_anim_sequencer_if;
  // No valid/ready pair here. Every request is level or pulse sampled on the
  // rising clock edge with no backpressure, and every output is valid each cycle.
  logic        anim_tick;
  logic [1:0]  move_req;
  logic        attack_trig;
  logic        hurt_trig;
`ifdef ANIM_FREEZE_EN
  logic        freeze;
`endif
  logic [10:0] anim_row;
  logic [10:0] anim_col;
  logic [5:0]  max_width;
  logic [2:0]  frame_idx;
  logic        hitbox_active;
  logic        busy;
  logic        anim_done;
  logic [2:0]  state_dbg;

  modport master (
    output anim_tick, move_req, attack_trig, hurt_trig,
`ifdef ANIM_FREEZE_EN
    output freeze,
`endif
    input  anim_row, anim_col, max_width, frame_idx, hitbox_active, busy, anim_done, state_dbg
  );

  modport slave (
    input  anim_tick, move_req, attack_trig, hurt_trig,
`ifdef ANIM_FREEZE_EN
    input  freeze,
`endif
    output anim_row, anim_col, max_width, frame_idx, hitbox_active, busy, anim_done, state_dbg
  );
endinterface

// File: rtl/koopa_anim_sequencer.sv
// Koopa animation sequencer: selects the animation, steps frames on anim_tick and emits sheet offsets.
// Optional feature macro: ANIM_FREEZE_EN (freeze input suspends anim_tick).
module koopa_anim_sequencer #(
  parameter int FRAME_W  = 48,
  parameter int FRAME_H  = 48,
  parameter int SPRITE_W = 46
) (
  input  logic                   clk,
  input  logic                   reset_n,
  koopa_anim_sequencer_if.slave  bus
);

  // The encoding doubles as the sprite-sheet row index.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK   = 3'd1,
    ST_JUMP   = 3'd2,
    ST_ATTACK = 3'd3,
    ST_HURT   = 3'd4
  } state_t;

  state_t     state_q, state_n;
  logic [2:0] frame_q, frame_n;
  logic [3:0] hold_q, hold_n;
  logic       done_q, done_n;

  logic [2:0] last_frame;
  logic [3:0] last_hold;
  logic       tick_eff;
  logic       is_busy;
  logic       is_last;
  logic       hold_expired;
  state_t     move_state;

`ifdef ANIM_FREEZE_EN
  assign tick_eff = bus.anim_tick & ~bus.freeze;
`else
  assign tick_eff = bus.anim_tick;
`endif

  always_comb begin
    last_frame = 3'd3;
    last_hold  = 4'd7;
    case (state_q)
      ST_IDLE:   begin last_frame = 3'd3; last_hold = 4'd7; end
      ST_WALK:   begin last_frame = 3'd5; last_hold = 4'd3; end
      ST_JUMP:   begin last_frame = 3'd2; last_hold = 4'd5; end
      ST_ATTACK: begin last_frame = 3'd4; last_hold = 4'd2; end
      ST_HURT:   begin last_frame = 3'd1; last_hold = 4'd9; end
      default:   begin last_frame = 3'd3; last_hold = 4'd7; end
    endcase
  end

  always_comb begin
    move_state = ST_IDLE;
    case (bus.move_req)
      2'd1:    move_state = ST_WALK;
      2'd2:    move_state = ST_JUMP;
      default: move_state = ST_IDLE;
    endcase
  end

  assign is_busy      = (state_q == ST_ATTACK) || (state_q == ST_HURT);
  assign is_last      = (frame_q == last_frame);
  assign hold_expired = (hold_q == last_hold);

  // Priority chain: hurt > attack > one-shot completion > movement change > tick.
  always_comb begin
    state_n = state_q;
    frame_n = frame_q;
    hold_n  = hold_q;
    done_n  = 1'b0;
    if (bus.hurt_trig) begin
      state_n = ST_HURT;
      frame_n = '0;
      hold_n  = '0;
    end else if (bus.attack_trig && !is_busy) begin
      state_n = ST_ATTACK;
      frame_n = '0;
      hold_n  = '0;
    end else if (is_busy && tick_eff && hold_expired && is_last) begin
      done_n  = 1'b1;
      state_n = move_state;
      frame_n = '0;
      hold_n  = '0;
    end else if (!is_busy && (move_state != state_q)) begin
      state_n = move_state;
      frame_n = '0;
      hold_n  = '0;
    end else if (tick_eff) begin
      if (state_q == ST_JUMP && is_last) begin
        // Jump parks on its final frame with the hold counter pinned.
        hold_n = '0;
      end else if (hold_expired) begin
        hold_n  = '0;
        frame_n = is_last ? 3'd0 : frame_q + 3'd1;
      end else begin
        hold_n = hold_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      frame_q <= frame_n;
      hold_q  <= hold_n;
      done_q  <= done_n;
    end
  end

  logic [10:0] row_base;
  logic [10:0] col_base;
  assign row_base = {8'd0, state_q};
  assign col_base = {8'd0, frame_q};

  assign bus.anim_row      = row_base * 11'(FRAME_H);
  assign bus.anim_col      = col_base * 11'(FRAME_W);
  assign bus.max_width     = 6'(SPRITE_W);
  assign bus.frame_idx     = frame_q;
  assign bus.hitbox_active = (state_q == ST_ATTACK) && ((frame_q == 3'd2) || (frame_q == 3'd3));
  assign bus.busy          = is_busy;
  assign bus.anim_done     = done_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_koopa_anim_sequencer.sv
// Directed, table-driven bench for koopa_anim_sequencer with hand-computed expectations.
// Define ANIM_FREEZE_EN to also exercise the freeze input.
module tb_koopa_anim_sequencer;
  localparam int W = 34;

  logic clk;
  logic reset_n;
  koopa_anim_sequencer_if bus ();

  koopa_anim_sequencer #(.FRAME_W(48), .FRAME_H(48), .SPRITE_W(46)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int         rep;
    logic       tick;
    logic [1:0] mv;
    logic       atk;
    logic       hrt;
    int         frame;
    int         row;
    int         col;
    logic       hit;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] pack_exp(int frame, int row, int col, logic hit, logic busy, logic done);
    logic [W-1:0] v;
    v = {6'd46, 3'(frame), 11'(row), 11'(col), hit, busy, done};
    return v;
  endfunction

  function automatic logic [W-1:0] observe();
    logic [W-1:0] v;
    v = {bus.max_width, bus.frame_idx, bus.anim_row, bus.anim_col, bus.hitbox_active, bus.busy, bus.anim_done};
    return v;
  endfunction

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got maxw=%0d frame=%0d row=%0d col=%0d hit=%0b busy=%0b done=%0b, expected maxw=%0d frame=%0d row=%0d col=%0d hit=%0b busy=%0b done=%0b",
               name, act[33:28], act[27:25], act[24:14], act[13:3], act[2], act[1], act[0],
               exp[33:28], exp[27:25], exp[24:14], exp[13:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add(input int rep, input logic tick, input logic [1:0] mv, input logic atk, input logic hrt,
                     input int frame, input int row, input int col, input logic hit, input logic busy, input logic done);
    vec_t v;
    v.rep = rep; v.tick = tick; v.mv = mv; v.atk = atk; v.hrt = hrt;
    v.frame = frame; v.row = row; v.col = col; v.hit = hit; v.busy = busy; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic step(input logic tick, input logic [1:0] mv, input logic atk, input logic hrt, input logic frz);
    @(negedge clk);
    bus.anim_tick   = tick;
    bus.move_req    = mv;
    bus.attack_trig = atk;
    bus.hurt_trig   = hrt;
`ifdef ANIM_FREEZE_EN
    bus.freeze      = frz;
`else
    if (frz) $display("note: freeze requested without ANIM_FREEZE_EN");
`endif
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] expw;

  initial begin
    bus.anim_tick   = 1'b0;
    bus.move_req    = 2'd0;
    bus.attack_trig = 1'b0;
    bus.hurt_trig   = 1'b0;
`ifdef ANIM_FREEZE_EN
    bus.freeze      = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_word("reset_state", observe(), pack_exp(0, 0, 0, 0, 0, 0));
    check_val("reset_state_dbg", int'(bus.state_dbg), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // IDLE loop: 4 frames, 8 ticks each
    add(7,  1, 0, 0, 0, 0,   0,   0, 0, 0, 0);
    add(1,  1, 0, 0, 0, 1,   0,  48, 0, 0, 0);
    add(8,  1, 0, 0, 0, 2,   0,  96, 0, 0, 0);
    add(8,  1, 0, 0, 0, 3,   0, 144, 0, 0, 0);
    add(8,  1, 0, 0, 0, 0,   0,   0, 0, 0, 0);
    // WALK entered mid-hold; 6 frames, 4 ticks each
    add(3,  1, 0, 0, 0, 0,   0,   0, 0, 0, 0);
    add(1,  1, 1, 0, 0, 0,  48,   0, 0, 0, 0);
    add(3,  1, 1, 0, 0, 0,  48,   0, 0, 0, 0);
    add(1,  1, 1, 0, 0, 1,  48,  48, 0, 0, 0);
    add(16, 1, 1, 0, 0, 5,  48, 240, 0, 0, 0);
    add(4,  1, 1, 0, 0, 0,  48,   0, 0, 0, 0);
    add(5,  0, 1, 0, 0, 0,  48,   0, 0, 0, 0);
    // ATTACK: 5 frames x 3 ticks, move_req churn ignored
    add(1,  1, 1, 1, 0, 0, 144,   0, 0, 1, 0);
    add(6,  1, 2, 0, 0, 2, 144,  96, 1, 1, 0);
    add(3,  1, 0, 0, 0, 3, 144, 144, 1, 1, 0);
    add(3,  1, 0, 0, 0, 4, 144, 192, 0, 1, 0);
    add(2,  1, 1, 0, 0, 4, 144, 192, 0, 1, 0);
    add(1,  1, 1, 0, 0, 0,  48,   0, 0, 0, 1);
    add(1,  0, 1, 0, 0, 0,  48,   0, 0, 0, 0);
    // HURT preempts ATTACK at frame 2; hurt+attack restarts HURT
    add(1,  0, 1, 1, 0, 0, 144,   0, 0, 1, 0);
    add(6,  1, 1, 0, 0, 2, 144,  96, 1, 1, 0);
    add(1,  1, 1, 0, 1, 0, 192,   0, 0, 1, 0);
    add(9,  1, 1, 0, 0, 0, 192,   0, 0, 1, 0);
    add(1,  1, 1, 1, 1, 0, 192,   0, 0, 1, 0);
    add(10, 1, 1, 0, 0, 1, 192,  48, 0, 1, 0);
    add(9,  1, 0, 0, 0, 1, 192,  48, 0, 1, 0);
    add(1,  1, 0, 0, 0, 0,   0,   0, 0, 0, 1);
    // JUMP: 3 frames x 6 ticks, parks on frame 2
    add(1,  0, 2, 0, 0, 0,  96,   0, 0, 0, 0);
    add(6,  1, 2, 0, 0, 1,  96,  48, 0, 0, 0);
    add(6,  1, 2, 0, 0, 2,  96,  96, 0, 0, 0);
    add(18, 1, 2, 0, 0, 2,  96,  96, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0,   0,   0, 0, 0, 0);
    // reserved move_req behaves as IDLE (no restart of the hold)
    add(1,  1, 3, 0, 0, 0,   0,   0, 0, 0, 0);
    add(7,  1, 3, 0, 0, 1,   0,  48, 0, 0, 0);
    // attack ignored during HURT, including on the completing tick
    add(1,  0, 0, 0, 1, 0, 192,   0, 0, 1, 0);
    add(1,  0, 0, 1, 0, 0, 192,   0, 0, 1, 0);
    add(19, 1, 0, 0, 0, 1, 192,  48, 0, 1, 0);
    add(1,  1, 0, 1, 0, 0,   0,   0, 0, 0, 1);

    foreach (vecs[i]) begin
      exp_q.push_back(pack_exp(vecs[i].frame, vecs[i].row, vecs[i].col, vecs[i].hit, vecs[i].busy, vecs[i].done));
      for (int r = 0; r < vecs[i].rep; r++)
        step(vecs[i].tick, vecs[i].mv, vecs[i].atk, vecs[i].hrt, 1'b0);
      expw = exp_q.pop_front();
      check_word($sformatf("vec%0d", i), observe(), expw);
    end

`ifdef ANIM_FREEZE_EN
    // WALK, two ticks in, then 20 frozen ticks, then resume at the same hold count
    step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    check_word("freeze_hold", observe(), pack_exp(0, 48, 0, 0, 0, 0));
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check_word("freeze_resume_hold3", observe(), pack_exp(0, 48, 0, 0, 0, 0));
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check_word("freeze_resume_adv", observe(), pack_exp(1, 48, 48, 0, 0, 0));
`endif

    // asynchronous reset in the middle of HURT
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check_word("hurt_before_reset", observe(), pack_exp(0, 192, 0, 0, 1, 0));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_word("async_reset", observe(), pack_exp(0, 0, 0, 0, 0, 0));
    check_val("async_reset_state_dbg", int'(bus.state_dbg), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_word("after_reset_idle", observe(), pack_exp(0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
